imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter alen, default 6: instruction-memory address width in words.
REQ-002 Parameter ilen, default 32: instruction word width in bits (multiple of 8).
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new load session; sampled in IDLE only.
REQ-006 len_words  input  alen+1  words to load, sampled with accepted start.
REQ-007 byte_valid  input  1  byte_data holds a valid byte.
REQ-008 byte_data  input  8  incoming program byte.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 we  output  1  instruction-memory write strobe.
REQ-011 waddr  output  alen  instruction-memory word address.
REQ-012 wdata  output  ilen  instruction word to write.
REQ-013 cpu_hold  output  1  holds the CPU program counter and register writes while loading.
REQ-014 busy  output  1  session in progress.
REQ-015 done  output  1  one-cycle pulse at session end.
REQ-016 err  output  1  checksum mismatch flag, sticky until next accepted start.

Function
REQ-017 States: IDLE, RECV, WRITE, CHECK (macro only), DONE.
REQ-018 IDLE: start=1 -> waddr cleared, byte counter cleared, err cleared, len latched; len 0 -> DONE, else -> RECV.
REQ-019 len_words above 2^alen SHALL be treated as 2^alen.
REQ-020 Byte transfer occurs only when byte_valid=1 and byte_ready=1; byte_ready=1 only in RECV and CHECK.
REQ-021 Packing: little-endian; first accepted byte of a word -> wdata[7:0], k-th byte -> wdata[8k+7:8k].
REQ-022 Accepting byte ilen/8 of a word -> WRITE next cycle; WRITE drives we=1 for exactly one cycle with current waddr and the packed word.
REQ-023 After WRITE: waddr increments (wraps modulo 2^alen); if words written < latched len -> RECV, else -> CHECK (macro) or DONE.
REQ-024 byte_valid held high in WRITE SHALL not be consumed; the byte waits.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 busy=1 and cpu_hold=1 in every state except IDLE; both fall in the cycle after DONE.
REQ-027 start asserted while busy SHALL be ignored.
REQ-028 we=0 in all states other than WRITE.

Reset
REQ-029 reset=0 SHALL immediately force IDLE and clear byte_ready, we, waddr, wdata, cpu_hold, busy, done, err, counters and checksum.
REQ-030 reset mid-session SHALL abandon the session; no further write occurs; partially packed bytes are discarded.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: running XOR of every accepted data byte; after last WRITE, CHECK accepts one byte; mismatch sets err=1 from DONE onward; then DONE.
REQ-032 Macro undefined: no CHECK state, no checksum logic, err tied to 0.

Structure
REQ-033 Package cpu_pkg SHALL hold alen/ilen default constants and the loader state enum typedef.
REQ-034 Sub-module word_packer (byte shift-in, byte count, word-complete flag) SHALL be instantiated once.

Verification
REQ-035 len=1, bytes 13,00,00,00 -> single we pulse, waddr=0, wdata=0x00000013, done pulse, cpu_hold low afterward.
REQ-036 len=3, bytes with byte_valid toggling every other cycle -> three writes to addresses 0,1,2 with correct words; no byte lost or duplicated.
REQ-037 len=0 -> done one cycle after start, no we pulse, byte_ready never high.
REQ-038 reset=0 after 6 of 8 bytes (len=2) -> only address 0 written, all outputs zero, next session starts at waddr=0.
REQ-039 Macro on, len=1, bytes AA,BB,CC,DD then checksum 0x00 -> err=0; checksum 0x01 -> err=1 and held until next start.
REQ-040 start pulsed during RECV -> ignored, waddr/counters unaffected, session completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the instruction-memory loader.
//   ALEN_DEF       : default instruction-memory address width (words)
//   ILEN_DEF       : default instruction word width (bits)
//   loader_state_e : loader FSM state encoding
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHECK state.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int ALEN_DEF = 6;
    localparam int ILEN_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// ---------------------------------------------------------------------------
// word_packer
// Little-endian byte-to-word assembler. The first byte after a clear lands
// in word[7:0], the k-th in word[8k+7:8k].
// Ports:
//   clock, reset   : clock, asynchronous active-low reset
//   clear          : discard any partial word and restart at byte 0
//   shift_en       : accept byte_in this cycle
//   byte_in        : incoming byte
//   word           : assembled word (registered)
//   word_complete  : combinational, high when the byte being accepted now
//                    is the last byte of the word
// ---------------------------------------------------------------------------
module word_packer
    import cpu_pkg::*;
#(
    parameter int ilen = ILEN_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            shift_en,
    input  logic [7:0]      byte_in,
    output logic [ilen-1:0] word,
    output logic            word_complete
);

    localparam int NB = ilen / 8;
    localparam int CW = $clog2(NB + 1);

    logic [ilen-1:0] word_q, word_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign word_complete = shift_en && (cnt_q == CW'(NB - 1));
    assign word          = word_q;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d[8*32'(cnt_q) +: 8] = byte_in;
            // Byte count restarts on its own once a word is full, so the
            // next word starts at lane 0 without an explicit clear.
            cnt_d = word_complete ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a program as a byte stream, packs bytes little-endian into
// instruction words and writes them to consecutive instruction-memory
// addresses starting at 0. The CPU is held for the whole session.
// Optional: IMEM_LOADER_CHECKSUM_EN appends a CHECK state that takes one
// extra byte and compares it with the XOR of all data bytes (err on
// mismatch). Without it err is constant 0.
// Ports:
//   clock, reset        : clock, asynchronous active-low reset
//   start, len_words    : session request and length (sampled in IDLE)
//   byte_valid/byte_data/byte_ready : byte stream input
//   we, waddr, wdata    : instruction-memory write port
//   cpu_hold, busy      : high in every state but IDLE
//   done                : one-cycle pulse at session end
//   err                 : checksum mismatch, sticky until next start
//   dbg_state           : current FSM state
//
// Byte handshake: a byte moves on a rising edge where byte_valid and
// byte_ready are both high; byte_ready depends only on the current state,
// so the sender may hold byte_valid and byte_data until that edge.
// ---------------------------------------------------------------------------
module imem_loader
    import cpu_pkg::*;
#(
    parameter int alen = ALEN_DEF,
    parameter int ilen = ILEN_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [alen:0]   len_words,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            we,
    output logic [alen-1:0] waddr,
    output logic [ilen-1:0] wdata,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [2:0]      dbg_state
);

    localparam logic [alen:0] MAX_LEN = {1'b1, {alen{1'b0}}};
    localparam logic [alen:0] ONE_W   = {{alen{1'b0}}, 1'b1};

    loader_state_e   state_q, state_d;
    logic [alen-1:0] waddr_q, waddr_d;
    logic [alen:0]   len_q, len_d;
    logic [alen:0]   words_q, words_d;
    logic [alen:0]   len_clamped;
    logic            accept;
    logic            pk_clear;
    logic            pk_shift;
    logic            pk_complete;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       err_q, err_d;
    assign err        = err_q;
    assign byte_ready = (state_q == ST_RECV) || (state_q == ST_CHECK);
`else
    assign err        = 1'b0;
    assign byte_ready = (state_q == ST_RECV);
`endif

    assign accept      = byte_valid && byte_ready;
    assign len_clamped = (len_words > MAX_LEN) ? MAX_LEN : len_words;

    assign we        = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign cpu_hold  = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign waddr     = waddr_q;
    assign dbg_state = state_q;

    word_packer #(
        .ilen (ilen)
    ) u_packer (
        .clock         (clock),
        .reset         (reset),
        .clear         (pk_clear),
        .shift_en      (pk_shift),
        .byte_in       (byte_data),
        .word          (wdata),
        .word_complete (pk_complete)
    );

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        len_d    = len_q;
        words_d  = words_q;
        pk_clear = 1'b0;
        pk_shift = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    waddr_d  = '0;
                    words_d  = '0;
                    len_d    = len_clamped;
                    pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d   = '0;
                    err_d    = 1'b0;
`endif
                    state_d  = (len_words == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (accept) begin
                    pk_shift = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ byte_data;
`endif
                    if (pk_complete) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                waddr_d = waddr_q + alen'(1);
                words_d = words_q + ONE_W;
                if ((words_q + ONE_W) < len_q) begin
                    state_d = ST_RECV;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    if (byte_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            len_q   <= '0;
            words_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            len_q   <= len_d;
            words_q <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Expected memory writes are pushed to
// exp_q when a session's bytes are chosen and popped by the write monitor.
// Works with or without IMEM_LOADER_CHECKSUM_EN defined.
// ---------------------------------------------------------------------------
module tb_imem_loader;
    import cpu_pkg::*;

    localparam int ALEN = 6;
    localparam int ILEN = 32;
    localparam int NB   = ILEN / 8;
    localparam int W    = ALEN + ILEN;

    logic            clock;
    logic            reset;
    logic            start;
    logic [ALEN:0]   len_words;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            byte_ready;
    logic            we;
    logic [ALEN-1:0] waddr;
    logic [ILEN-1:0] wdata;
    logic            cpu_hold;
    logic            busy;
    logic            done;
    logic            err;
    logic [2:0]      dbg_state;

    imem_loader #(
        .alen (ALEN),
        .ilen (ILEN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int ready_seen   = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   byte_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin : write_monitor
        logic [W-1:0] e;
        if (byte_ready === 1'b1) ready_seen++;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_we", 64'(we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("waddr", 64'(waddr), 64'(e[W-1:ILEN]));
                check_eq("wdata", 64'(wdata), 64'(e[ILEN-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_random(input int nbytes);
        byte_q.delete();
        for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference packing: byte k of word w lands in bits [8k+7:8k].
    task automatic push_model(input int nwords);
        logic [ILEN-1:0] word;
        for (int w = 0; w < nwords; w++) begin
            word = '0;
            for (int k = 0; k < NB; k++) word[8*k +: 8] = byte_q[w*NB + k];
            exp_q.push_back({ALEN'(w), word});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clock);
        while (byte_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (byte_ready !== 1'b1) check_eq("byte_accept_timeout", 64'(byte_ready), 64'd1);
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic start_session(input logic [ALEN:0] len);
        start     = 1'b1;
        len_words = len;
        tick();
        start     = 1'b0;
        len_words = (ALEN+1)'($urandom_range(0, 127));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, 64'(done), 64'd1);
    endtask

    // Runs a full session with the bytes already in byte_q.
    task automatic run_session(input logic [ALEN:0] len, input int gap, input int poke_idx,
                               input bit bad_csum, input string tag);
        int         eff;
        int         rbase;
        logic [7:0] cs;
        eff   = (len > (ALEN+1)'(64)) ? 64 : int'(len);
        push_model(eff);
        rbase = ready_seen;
        start_session(len);
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        check_eq({tag, "_hold"}, 64'(cpu_hold), 64'd1);
        check_eq({tag, "_err_cleared"}, 64'(err), 64'd0);
        if (eff == 0) check_eq({tag, "_done_next"}, 64'(done), 64'd1);
        cs = 8'h00;
        for (int i = 0; i < byte_q.size(); i++) begin
            if (i == poke_idx) begin
                start     = 1'b1;
                len_words = 7'd5;
            end
            send_byte(byte_q[i]);
            if (i == poke_idx) start = 1'b0;
            cs = cs ^ byte_q[i];
            repeat (gap) tick();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (eff != 0) send_byte(cs ^ {7'd0, bad_csum});
`endif
        wait_done({tag, "_done"});
        tick();
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
        check_eq({tag, "_hold_after"}, 64'(cpu_hold), 64'd0);
        check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq({tag, "_err"}, 64'(err), 64'(bad_csum));
`else
        check_eq({tag, "_err"}, 64'(err), 64'd0);
`endif
        if (eff == 0) check_eq({tag, "_ready_never"}, 64'(ready_seen - rbase), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_we"}, 64'(we), 64'd0);
        check_eq({tag, "_waddr"}, 64'(waddr), 64'd0);
        check_eq({tag, "_wdata"}, 64'(wdata), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check_eq({tag, "_err"}, 64'(err), 64'd0);
        check_eq({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        len_words  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Single word, fixed bytes 13,00,00,00.
        byte_q.delete();
        byte_q.push_back(8'h13);
        byte_q.push_back(8'h00);
        byte_q.push_back(8'h00);
        byte_q.push_back(8'h00);
        run_session(7'd1, 0, -1, 1'b0, "len1");

        // Three words, byte_valid dropping every other cycle.
        fill_random(3 * NB);
        run_session(7'd3, 1, -1, 1'b0, "len3_gap");

        // Zero-length session.
        byte_q.delete();
        run_session(7'd0, 0, -1, 1'b0, "len0");

        // Reset after 6 of 8 bytes: only word 0 may be written.
        fill_random(2 * NB);
        push_model(1);
        start_session(7'd2);
        for (int i = 0; i < 6; i++) send_byte(byte_q[i]);
        reset = 1'b0;
        #2;
        check_all_zero("midrst");
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check_eq("midrst_pending_writes", 64'(exp_q.size()), 64'd0);
        fill_random(NB);
        run_session(7'd1, 0, -1, 1'b0, "after_rst");

        // start pulsed mid-session must be ignored.
        fill_random(2 * NB);
        run_session(7'd2, 0, 2, 1'b0, "start_ignored");

        // Length above 2^alen is clamped to 2^alen words.
        fill_random(64 * NB);
        run_session(7'd100, 0, -1, 1'b0, "clamp");

        // Checksum: good, then bad with sticky err, then cleared by start.
        byte_q.delete();
        byte_q.push_back(8'hAA);
        byte_q.push_back(8'hBB);
        byte_q.push_back(8'hCC);
        byte_q.push_back(8'hDD);
        run_session(7'd1, 0, -1, 1'b0, "csum_good");
        run_session(7'd1, 0, -1, 1'b1, "csum_bad");
        repeat (5) tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("csum_err_sticky", 64'(err), 64'd1);
`else
        check_eq("csum_err_sticky", 64'(err), 64'd0);
`endif
        fill_random(2 * NB);
        run_session(7'd2, 1, -1, 1'b0, "final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
